ex_mdu: RTL and testbench

Multiply/divide unit in the EX stage, alongside the ALU. It executes mult/multu/div/divu over a fixed multi-cycle latency and owns the architectural HI/LO registers. It also handles mthi/mtlo writes and supplies HI/LO to the EX result mux for mfhi/mflo; that value is then latched into the EX/MEM pipeline register. Hazard logic uses its stall output to freeze IF/ID/EX while an operation is in flight.

---
 rtl/ex_mdu_if.sv | 29 ++
 rtl/ex_mdu.sv | 142 ++++++++++++++
 tb/tb_ex_mdu.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ex_mdu_if.sv
// ex_mdu_if: EX-stage connection bundle for the multiply/divide unit.
//   start     - EX holds a valid MDU op this cycle
//   op        - 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no-op
//   rs_data   - forwarded rs operand (dividend / multiplicand / mthi-mtlo source)
//   rt_data   - forwarded rt operand (divisor / multiplier)
//   busy      - mult/div in flight
//   stall_req - freeze request for the hazard unit
//   hi, lo    - architectural HI/LO registers
// master: pipeline side; slave: the MDU.
interface ex_mdu_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_data, rt_data,
        input  busy, stall_req, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data,
        output busy, stall_req, hi, lo
    );
endinterface

// File: rtl/ex_mdu.sv
// ex_mdu: multi-cycle multiply/divide unit owning the HI/LO registers.
// The result is computed from the operands sampled at issue and parked in
// shadow registers; HI/LO take it when the busy window closes.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous, active-low
//   bus   - ex_mdu_if.slave (start/op/rs_data/rt_data in; busy/stall_req/hi/lo out)
module ex_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    ex_mdu_if.slave   bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic [31:0]      hi;
    logic [31:0]      lo;
    logic [31:0]      shadow_hi;
    logic [31:0]      shadow_lo;

    logic             is_muldiv;
    logic             issue;
    logic [63:0]      prod_s;
    logic [63:0]      prod_u;
    logic             div_signed;
    logic [31:0]      div_a;
    logic [31:0]      div_b;
    logic [31:0]      div_b_safe;
    logic [31:0]      quot_mag;
    logic [31:0]      rem_mag;
    logic [31:0]      quot;
    logic [31:0]      rem;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;

    assign is_muldiv = ~bus.op[2];
    assign issue     = (state == IDLE) && bus.start && is_muldiv;

    // Result datapath. Signed divide runs on magnitudes so that
    // 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
    always_comb begin
        prod_s     = {{32{bus.rs_data[31]}}, bus.rs_data} * {{32{bus.rt_data[31]}}, bus.rt_data};
        prod_u     = {32'h0, bus.rs_data} * {32'h0, bus.rt_data};
        div_signed = (bus.op == 3'd2);
        div_a      = (div_signed && bus.rs_data[31]) ? (32'h0 - bus.rs_data) : bus.rs_data;
        div_b      = (div_signed && bus.rt_data[31]) ? (32'h0 - bus.rt_data) : bus.rt_data;
        div_b_safe = (div_b == '0) ? 32'h1 : div_b;
        quot_mag   = div_a / div_b_safe;
        rem_mag    = div_a % div_b_safe;
        quot       = (div_signed && (bus.rs_data[31] ^ bus.rt_data[31])) ? (32'h0 - quot_mag) : quot_mag;
        rem        = (div_signed && bus.rs_data[31]) ? (32'h0 - rem_mag) : rem_mag;

        res_hi = hi;
        res_lo = lo;
        case (bus.op)
            3'd0:    {res_hi, res_lo} = prod_s;
            3'd1:    {res_hi, res_lo} = prod_u;
            default: begin
                // Divide by zero leaves HI/LO as they are at completion;
                // HI/LO cannot change while busy, so capturing them now is exact.
                if (bus.rt_data != '0) begin
                    res_hi = rem;
                    res_lo = quot;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue) state_next = RUN;
            RUN:     if (count == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counter loads N-1 and the op retires on the edge that sees zero,
    // giving exactly N busy cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi        <= '0;
            lo        <= '0;
            shadow_hi <= '0;
            shadow_lo <= '0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (is_muldiv) begin
                            shadow_hi <= res_hi;
                            shadow_lo <= res_lo;
                            count     <= bus.op[1] ? DIV_LOAD : MULT_LOAD;
                        end else if (bus.op == 3'd4) begin
                            hi <= bus.rs_data;
                        end else if (bus.op == 3'd5) begin
                            lo <= bus.rs_data;
                        end
                    end
                end
                RUN: begin
                    if (count == '0) begin
                        hi <= shadow_hi;
                        lo <= shadow_lo;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state == RUN);
    assign bus.stall_req = (state == RUN) | (bus.start & is_muldiv);
    assign bus.hi        = hi;
    assign bus.lo        = lo;

endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: directed bench for ex_mdu with a reference model checked every cycle.
module tb_ex_mdu;
    logic clk;
    logic rst_n;

    int checks = 0;
    int passed = 0;

    ex_mdu_if bus ();

    ex_mdu #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: cycles remaining + pending result.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    int          m_left;

    always @(posedge clk or negedge rst_n) begin
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     prod;
        int              da, db;
        int unsigned     qa, qb;
        if (!rst_n) begin
            m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (bus.start) begin
            case (bus.op)
                3'd0: begin
                    sa = $signed(bus.rs_data); sb = $signed(bus.rt_data);
                    prod = sa * sb;
                    {p_hi, p_lo} = prod; m_left = 5;
                end
                3'd1: begin
                    ua = bus.rs_data; ub = bus.rt_data;
                    prod = ua * ub;
                    {p_hi, p_lo} = prod; m_left = 5;
                end
                3'd2: begin
                    m_left = 10;
                    if (bus.rt_data == 0) begin
                        p_hi = m_hi; p_lo = m_lo;
                    end else if (bus.rs_data == 32'h80000000 && bus.rt_data == 32'hFFFFFFFF) begin
                        p_lo = 32'h80000000; p_hi = 0;
                    end else begin
                        da = $signed(bus.rs_data); db = $signed(bus.rt_data);
                        p_lo = da / db; p_hi = da % db;
                    end
                end
                3'd3: begin
                    m_left = 10;
                    if (bus.rt_data == 0) begin
                        p_hi = m_hi; p_lo = m_lo;
                    end else begin
                        qa = bus.rs_data; qb = bus.rt_data;
                        p_lo = qa / qb; p_hi = qa % qb;
                    end
                end
                3'd4: m_hi = bus.rs_data;
                3'd5: m_lo = bus.rs_data;
                default: ;
            endcase
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic m_busy;
        m_busy = (m_left > 0);
        check("busy", {31'h0, bus.busy}, {31'h0, m_busy});
        check("stall_req", {31'h0, bus.stall_req},
              {31'h0, m_busy | (bus.start & (bus.op <= 3'd3))});
        check("hi", bus.hi, m_hi);
        check("lo", bus.lo, m_lo);
    end

    task automatic drive(input logic s, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        bus.start = s; bus.op = o; bus.rs_data = a; bus.rt_data = b;
    endtask

    // Present one op for a single edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        drive(1'b1, o, a, b);
        drive(1'b0, 3'd7, 32'h0, 32'h0);
    endtask

    // Count remaining busy cycles (sampled at negedge) until idle, bounded.
    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            n++;
        end
        if (bus.busy) check("timeout_busy", 32'h1, 32'h0);
        #1;
    endtask

    int n;

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = 3'd7; bus.rs_data = '0; bus.rt_data = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_hi", bus.hi, 32'h0);
        check("rst_lo", bus.lo, 32'h0);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // mult / multu
        issue(3'd0, 32'hFFFFFFFE, 32'd3);
        wait_idle(n);
        check("mult_lat", n, 32'd5);
        check("mult_hi", bus.hi, 32'hFFFFFFFF);
        check("mult_lo", bus.lo, 32'hFFFFFFFA);
        issue(3'd1, 32'hFFFFFFFE, 32'd3);
        wait_idle(n);
        check("multu_lat", n, 32'd5);
        check("multu_hi", bus.hi, 32'h00000002);
        check("multu_lo", bus.lo, 32'hFFFFFFFA);

        // div / divu
        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        wait_idle(n);
        check("div_lat", n, 32'd10);
        check("div_lo", bus.lo, 32'hFFFFFFFD);
        check("div_hi", bus.hi, 32'hFFFFFFFF);
        issue(3'd3, 32'd7, 32'd2);
        wait_idle(n);
        check("divu_lat", n, 32'd10);
        check("divu_lo", bus.lo, 32'd3);
        check("divu_hi", bus.hi, 32'd1);

        // mthi then mtlo back to back
        drive(1'b1, 3'd4, 32'h12345678, 32'h0);
        check("mthi_stall", {31'h0, bus.stall_req}, 32'h0);
        drive(1'b1, 3'd5, 32'h9ABCDEF0, 32'h0);
        check("mthi_hi", bus.hi, 32'h12345678);
        check("mthi_busy", {31'h0, bus.busy}, 32'h0);
        drive(1'b0, 3'd7, 32'h0, 32'h0);
        check("mtlo_lo", bus.lo, 32'h9ABCDEF0);
        check("mtlo_busy", {31'h0, bus.busy}, 32'h0);

        // divide by zero keeps HI/LO
        drive(1'b1, 3'd4, 32'hAAAA0000, 32'h0);
        drive(1'b1, 3'd5, 32'h00005555, 32'h0);
        drive(1'b0, 3'd7, 32'h0, 32'h0);
        issue(3'd3, 32'd1234, 32'd0);
        wait_idle(n);
        check("div0_lat", n, 32'd10);
        check("div0_hi", bus.hi, 32'hAAAA0000);
        check("div0_lo", bus.lo, 32'h00005555);
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_idle(n);
        check("ovf_lo", bus.lo, 32'h80000000);
        check("ovf_hi", bus.hi, 32'h0);

        // start / mthi during busy are ignored
        issue(3'd0, 32'h1234, 32'h10);
        drive(1'b1, 3'd0, 32'd7, 32'd9);
        check("inflight_stall1", {31'h0, bus.stall_req}, 32'h1);
        drive(1'b1, 3'd4, 32'hDEAD, 32'h0);
        check("inflight_stall2", {31'h0, bus.stall_req}, 32'h1);
        drive(1'b0, 3'd7, 32'h0, 32'h0);
        check("inflight_busy", {31'h0, bus.busy}, 32'h1);
        wait_idle(n);
        check("inflight_hi", bus.hi, 32'h0);
        check("inflight_lo", bus.lo, 32'h00012340);
        check("inflight_stall_end", {31'h0, bus.stall_req}, 32'h0);

        // reset in the middle of a div
        issue(3'd3, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'h0, bus.busy}, 32'h0);
        check("midrst_hi", bus.hi, 32'h0);
        check("midrst_lo", bus.lo, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        repeat (15) @(posedge clk);
        #2;
        check("post_rst_hi", bus.hi, 32'h0);
        check("post_rst_lo", bus.lo, 32'h0);
        check("post_rst_busy", {31'h0, bus.busy}, 32'h0);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
